// File: rtl/cpu_pkg.sv
// Shared definitions for the front end of the CPU.
//   XLEN             : datapath / address width
//   NOP_INST         : canonical no-op (addi x0,x0,0)
//   RESET_PC_DEFAULT : default program counter after reset
//   INST_BYTES       : size of one instruction word in bytes
//   fetch_state_t    : instruction fetch controller states
package cpu_pkg;

    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] INST_BYTES       = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_out_buf.sv
// Single-entry output register between fetch and decode.
// Holds the instruction word, its PC and the qualifying enable.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_load        : capture i_load_code / i_load_pc and raise o_en
//   i_load_code   : instruction word to capture
//   i_load_pc     : PC of the captured word
//   i_consume     : decoder takes the current word this cycle
//   i_flush       : drop the current word (o_en low, code back to NOP)
//   i_trap_load   : with i_flush, record i_trap_pc in o_pc for trap reporting
//   i_trap_pc     : faulting PC
//   o_en          : o_code / o_pc valid
//   o_code        : instruction to decoder (NOP whenever o_en is low)
//   o_pc          : PC of o_code
module fetch_out_buf #(
    parameter logic [cpu_pkg::XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC_DEFAULT,
    parameter logic [cpu_pkg::XLEN-1:0] NOP_INST = cpu_pkg::NOP_INST
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_load,
    input  logic [cpu_pkg::XLEN-1:0] i_load_code,
    input  logic [cpu_pkg::XLEN-1:0] i_load_pc,
    input  logic                     i_consume,
    input  logic                     i_flush,
    input  logic                     i_trap_load,
    input  logic [cpu_pkg::XLEN-1:0] i_trap_pc,
    output logic                     o_en,
    output logic [cpu_pkg::XLEN-1:0] o_code,
    output logic [cpu_pkg::XLEN-1:0] o_pc
);

    logic                     r_en;
    logic [cpu_pkg::XLEN-1:0] r_code;
    logic [cpu_pkg::XLEN-1:0] r_pc;

    // Flush beats load beats consume. A held word keeps code and PC stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en   <= 1'b0;
            r_code <= NOP_INST;
            r_pc   <= RESET_PC;
        end else if (i_flush) begin
            r_en   <= 1'b0;
            r_code <= NOP_INST;
            if (i_trap_load) begin
                r_pc <= i_trap_pc;
            end
        end else if (i_load) begin
            r_en   <= 1'b1;
            r_code <= i_load_code;
            r_pc   <= i_load_pc;
        end else if (i_consume && r_en) begin
            r_en   <= 1'b0;
            r_code <= NOP_INST;
        end
    end

    assign o_en   = r_en;
    assign o_code = r_code;
    assign o_pc   = r_pc;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, fetches one word at a time from
// instruction memory and hands it to the decoder through fetch_out_buf.
// Branch redirects from execute replace the PC and squash wrong-path fetches.
//
// Handshakes: a request transfers on a cycle where imem_req_valid and
// imem_req_ready are both high; exactly one response (imem_rsp_valid)
// returns per transferred request, in order. The decoder takes the word
// on any cycle where en and dec_ready are both high.
//
// Build option: FETCH_MISALIGN_CHECK_EN
//   defined   - a redirect to a non word-aligned target faults and reports
//               the target on inst_pc
//   undefined - the low two bits of the redirect target are cleared
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   imem_req_valid/ready: fetch request handshake
//   imem_req_addr       : fetch address (always the current PC)
//   imem_rsp_valid/data/err : fetch response
//   dec_ready           : decoder consumes the presented word
//   redirect_valid/pc   : taken branch / jump target
//   en, instruction_code, inst_pc : word presented to the decoder
//   fetch_fault         : sticky bus error / misalign flag
//   dbg_state           : current controller state (observation only)
module instruction_fetch #(
    parameter logic [cpu_pkg::XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC_DEFAULT,
    parameter logic [cpu_pkg::XLEN-1:0] NOP_INST = cpu_pkg::NOP_INST
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [cpu_pkg::XLEN-1:0] imem_req_addr,
    input  logic                     imem_rsp_valid,
    input  logic [cpu_pkg::XLEN-1:0] imem_rsp_data,
    input  logic                     imem_rsp_err,
    input  logic                     dec_ready,
    input  logic                     redirect_valid,
    input  logic [cpu_pkg::XLEN-1:0] redirect_pc,
    output logic                     en,
    output logic [cpu_pkg::XLEN-1:0] instruction_code,
    output logic [cpu_pkg::XLEN-1:0] inst_pc,
    output logic                     fetch_fault,
    output logic [1:0]               dbg_state
);

    import cpu_pkg::XLEN;
    import cpu_pkg::INST_BYTES;
    import cpu_pkg::fetch_state_t;
    import cpu_pkg::IDLE;
    import cpu_pkg::REQ;
    import cpu_pkg::WAIT;
    import cpu_pkg::FAULT;

    localparam logic [XLEN-1:0] PC_ALIGN_MASK = ~32'h0000_0003;

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_drop;   // the outstanding request is wrong-path
    logic            r_fault;

    logic            w_en;
    logic            w_slot_free;
    logic            w_hs;
    logic            w_rsp_wait;
    logic            w_rsp_good;
    logic            w_rsp_err;
    logic            w_pending;
    logic            w_misalign;
    logic            w_load;
    logic            w_flush;
    logic [XLEN-1:0] w_redirect_target;

    // Only request when the output slot can take the word, so a returning
    // response never has to be stalled.
    assign w_slot_free    = !w_en || dec_ready;
    assign imem_req_valid = (r_state == REQ) && w_slot_free;
    assign imem_req_addr  = r_pc;
    assign w_hs           = imem_req_valid && imem_req_ready;

    assign w_rsp_wait = (r_state == WAIT) && imem_rsp_valid;
    assign w_rsp_good = w_rsp_wait && !r_drop && !imem_rsp_err;
    assign w_rsp_err  = w_rsp_wait && !r_drop && imem_rsp_err;

    // After a redirect, is a wrong-path response still on its way?
    // Either a request transfers this cycle, or we were already waiting and
    // the response does not arrive this cycle (a same-cycle response is
    // simply discarded).
    assign w_pending = ((r_state == REQ)   && w_hs) ||
                       ((r_state == WAIT)  && !imem_rsp_valid) ||
                       ((r_state == FAULT) && r_drop && !imem_rsp_valid);

`ifdef FETCH_MISALIGN_CHECK_EN
    assign w_misalign        = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign w_redirect_target = redirect_pc;
`else
    assign w_misalign        = 1'b0;
    assign w_redirect_target = redirect_pc & PC_ALIGN_MASK;
`endif

    assign w_load  = !redirect_valid && w_rsp_good;
    assign w_flush = redirect_valid || w_rsp_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
            r_drop  <= 1'b0;
            r_fault <= 1'b0;
        end else if (redirect_valid) begin
            r_pc    <= w_redirect_target;
            r_drop  <= w_pending;
            r_fault <= w_misalign;
            if (w_misalign) begin
                r_state <= FAULT;
            end else if (w_pending) begin
                r_state <= WAIT;
            end else begin
                r_state <= REQ;
            end
        end else begin
            case (r_state)
                IDLE: r_state <= REQ;
                REQ: begin
                    if (w_hs) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (r_drop) begin
                            r_drop  <= 1'b0;
                            r_state <= REQ;
                        end else if (imem_rsp_err) begin
                            r_fault <= 1'b1;
                            r_state <= FAULT;
                        end else begin
                            r_pc    <= r_pc + INST_BYTES;
                            r_state <= REQ;
                        end
                    end
                end
                FAULT: begin
                    // A wrong-path response can only be pending here after a
                    // misaligned redirect; retire it so it is not mistaken
                    // for the next fetch.
                    if (imem_rsp_valid && r_drop) begin
                        r_drop <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    fetch_out_buf #(
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP_INST)
    ) u_out_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_load),
        .i_load_code (imem_rsp_data),
        .i_load_pc   (r_pc),
        .i_consume   (dec_ready),
        .i_flush     (w_flush),
        .i_trap_load (w_misalign),
        .i_trap_pc   (redirect_pc),
        .o_en        (w_en),
        .o_code      (instruction_code),
        .o_pc        (inst_pc)
    );

    assign en          = w_en;
    assign fetch_fault = r_fault;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: randomized memory / decoder / redirect
// stimulus against a transaction-level reference of the fetch rules.
module tb_instruction_fetch;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;
    localparam logic [31:0] STALE_W  = 32'hDEAD_BEEF;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        dec_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        en;
    logic [31:0] instruction_code;
    logic [31:0] inst_pc;
    logic        fetch_fault;
    logic [1:0]  dbg_state;

    instruction_fetch dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_req_addr    (imem_req_addr),
        .imem_rsp_valid   (imem_rsp_valid),
        .imem_rsp_data    (imem_rsp_data),
        .imem_rsp_err     (imem_rsp_err),
        .dec_ready        (dec_ready),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .en               (en),
        .instruction_code (instruction_code),
        .inst_pc          (inst_pc),
        .fetch_fault      (fetch_fault),
        .dbg_state        (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];   // words the decoder is expected to take, in order

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_started;   // first edge after reset seen
    bit          m_out;       // one request outstanding at memory
    bit          m_stale;     // the outstanding request has been squashed
    bit          m_fault;
    bit          m_en;
    logic [31:0] m_code;
    logic [31:0] m_ipc;
    logic [31:0] m_pc;

    task automatic model_reset();
        m_started = 0; m_out = 0; m_stale = 0; m_fault = 0; m_en = 0;
        m_code = NOP; m_ipc = RST_PC; m_pc = RST_PC;
        exp_q.delete();
    endtask

    task automatic model_step(input bit hs, input bit s_dec, input bit s_redir,
                              input logic [31:0] s_tgt, input bit s_rsp,
                              input bit s_err, input logic [31:0] s_data);
        if (s_redir) begin
            if (m_en && !s_dec && exp_q.size() > 0) void'(exp_q.pop_back());
            m_en = 0; m_code = NOP; m_fault = 0;
`ifdef FETCH_MISALIGN_CHECK_EN
            m_pc = s_tgt;
            if (s_tgt[1:0] != 2'b00) begin
                m_fault = 1;
                m_ipc = s_tgt;
            end
`else
            m_pc = {s_tgt[31:2], 2'b00};
`endif
            if (m_out && s_rsp) m_out = 0;
            else if (m_out) m_stale = 1;
            else if (hs) begin m_out = 1; m_stale = 1; end
            if (!m_out) m_stale = 0;
        end else begin
            if (m_en && s_dec) begin m_en = 0; m_code = NOP; end
            if (m_out && s_rsp) begin
                m_out = 0;
                if (m_stale) m_stale = 0;
                else if (s_err) begin m_fault = 1; m_en = 0; m_code = NOP; end
                else begin
                    m_en = 1; m_code = s_data; m_ipc = m_pc; m_pc = m_pc + 32'd4;
                    exp_q.push_back(s_data);
                end
            end else if (hs) begin
                m_out = 1; m_stale = 0;
            end
        end
        m_started = 1;
    endtask

    // ---------------- memory / environment ----------------
    logic [31:0] mem_addr_q[$];
    int          mem_cnt_q[$];
    int ready_pct, dec_pct, redir_pct, err_pct, spur_pct, lat_min, lat_max;
    bit          force_redir, force_in_wait, stale_override;
    logic [31:0] force_tgt;
    logic [31:0] tgt_tab[6];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic drive_idle();
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0; imem_rsp_err = 0;
        dec_ready = 0; redirect_valid = 0; redirect_pc = 0;
    endtask

    task automatic set_knobs(input int rdy, input int dec, input int rdr, input int err,
                             input int spur, input int lmin, input int lmax);
        ready_pct = rdy; dec_pct = dec; redir_pct = rdr; err_pct = err;
        spur_pct = spur; lat_min = lmin; lat_max = lmax;
    endtask

    // One cycle per iteration: drive on negedge, check #1 later, model on posedge.
    task automatic run_cycles(input int n);
        bit s_rsp, s_err, s_dec, s_ready, s_redir, req_exp;
        logic [31:0] s_data, s_tgt;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            s_rsp = 0; s_err = 0; s_data = 32'h0;
            if (mem_addr_q.size() > 0) begin
                if (mem_cnt_q[0] == 0) begin
                    s_rsp = 1;
                    s_data = stale_override ? STALE_W : mem_word(mem_addr_q[0]);
                    stale_override = 0;
                    s_err = ($urandom_range(0, 99) < err_pct);
                    void'(mem_addr_q.pop_front());
                    void'(mem_cnt_q.pop_front());
                end else begin
                    mem_cnt_q[0] = mem_cnt_q[0] - 1;
                end
            end else if ($urandom_range(0, 99) < spur_pct) begin
                s_rsp = 1; s_data = $urandom; s_err = 1'($urandom_range(0, 1));
            end
            s_dec   = ($urandom_range(0, 99) < dec_pct);
            s_ready = ($urandom_range(0, 99) < ready_pct);
            s_redir = ($urandom_range(0, 99) < redir_pct);
            s_tgt   = ($urandom_range(0, 3) == 0) ? $urandom : tgt_tab[$urandom_range(0, 5)];
            if (force_redir && (!force_in_wait || (m_out && !m_stale))) begin
                s_redir = 1; s_tgt = force_tgt; force_redir = 0;
            end
            imem_rsp_valid = s_rsp; imem_rsp_data = s_data; imem_rsp_err = s_err;
            dec_ready = s_dec; imem_req_ready = s_ready;
            redirect_valid = s_redir; redirect_pc = s_tgt;
            #1;
            req_exp = m_started && !m_fault && !m_out && (!m_en || s_dec);
            check_eq("req_valid", imem_req_valid, req_exp);
            check_eq("req_addr", imem_req_addr, m_pc);
            check_eq("en", en, m_en);
            check_eq("instruction_code", instruction_code, m_code);
            check_eq("inst_pc", inst_pc, m_ipc);
            check_eq("fetch_fault", fetch_fault, m_fault);
            if (en && s_dec) begin
                if (exp_q.size() == 0) check_eq("deliver_extra", 32'(exp_q.size()), 32'd1);
                else check_eq("deliver", instruction_code, exp_q.pop_front());
            end
            if (imem_req_valid && imem_req_ready) begin
                mem_addr_q.push_back(imem_req_addr);
                mem_cnt_q.push_back($urandom_range(lat_min, lat_max) - 1);
            end
            @(posedge clk);
            model_step(req_exp && s_ready, s_dec, s_redir, s_tgt, s_rsp, s_err, s_data);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_valid"}, imem_req_valid, 1'b0);
        check_eq({tag, "_req_addr"}, imem_req_addr, RST_PC);
        check_eq({tag, "_en"}, en, 1'b0);
        check_eq({tag, "_code"}, instruction_code, NOP);
        check_eq({tag, "_inst_pc"}, inst_pc, RST_PC);
        check_eq({tag, "_fault"}, fetch_fault, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        tgt_tab[0] = 32'h0000_0100; tgt_tab[1] = 32'h0000_0200;
        tgt_tab[2] = 32'hFFFF_FFFC; tgt_tab[3] = 32'hFFFF_FFF8;
        tgt_tab[4] = 32'h0000_1002; tgt_tab[5] = 32'h0000_0041;
        force_redir = 0; force_in_wait = 0; stale_override = 0; force_tgt = 0;
        drive_idle();
        model_reset();
        set_knobs(100, 100, 0, 0, 0, 1, 1);
        #13;
        check_reset_outputs("reset");
        @(posedge clk); #1 rst_n = 1;

        // steady stream: 0x0, 0x4, 0x8 ... one word per two cycles
        run_cycles(14);

        // decoder stalls with a word held, then resumes
        set_knobs(100, 0, 0, 0, 0, 1, 1);
        run_cycles(8);
        set_knobs(100, 100, 0, 0, 0, 1, 1);
        run_cycles(4);

        // redirect while waiting, stale response arrives the next cycle
        set_knobs(100, 100, 0, 0, 0, 2, 2);
        force_redir = 1; force_in_wait = 1; force_tgt = 32'h0000_0100; stale_override = 1;
        run_cycles(14);

        // redirect coincident with the response
        set_knobs(100, 100, 0, 0, 0, 1, 1);
        force_redir = 1; force_in_wait = 1; force_tgt = 32'h0000_0040;
        run_cycles(10);

        // bus error locks up fetch until a redirect
        set_knobs(100, 100, 0, 100, 0, 1, 1);
        run_cycles(6);
        set_knobs(100, 100, 0, 0, 0, 1, 1);
        run_cycles(5);
        force_redir = 1; force_in_wait = 0; force_tgt = 32'h0000_0200;
        run_cycles(8);

        // PC wrap at the top of the address space
        force_redir = 1; force_in_wait = 0; force_tgt = 32'hFFFF_FFF8;
        run_cycles(10);

        // reset in the middle of a fetch
        set_knobs(100, 100, 0, 0, 0, 3, 3);
        for (int i = 0; i < 40 && !m_out; i++) run_cycles(1);
        check_eq("reach_wait", m_out, 1'b1);
        #2 rst_n = 0;
        drive_idle();
        #1;
        check_reset_outputs("mid_reset");
        model_reset();
        mem_addr_q.delete(); mem_cnt_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        set_knobs(100, 100, 0, 0, 100, 1, 1);
        run_cycles(3);

        // randomized soak
        set_knobs(70, 70, 10, 5, 5, 1, 3);
        run_cycles(400);
        set_knobs(40, 40, 20, 10, 10, 1, 4);
        run_cycles(300);
        set_knobs(100, 100, 3, 0, 0, 1, 1);
        run_cycles(100);

        check_eq("exp_q_left", 32'(exp_q.size()), 32'(m_en));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
